// File: rtl/hex_count_sequencer.sv
// hex_count_sequencer
//
// Produces the 4-bit count that feeds the 7-segment decoder. The board clock
// is divided down to a step rate, and the count moves up or down, wrapping
// within 0..MODULUS-1. Two raw push-buttons (run/pause toggle and
// single-step) are synchronized and debounced on-chip. A synchronous parallel
// load takes priority over everything except reset.
//
// Optional build macro: HEX_SEQ_BOUNCE_EN
//   When defined, the count bounces between the ends of its range instead of
//   wrapping. An internal direction register (reset = up) replaces the dir
//   port, and the register takes the value of dir on a load.
//
// Parameters:
//   PRESCALE   - clk cycles per count step while running (>= 2)
//   MODULUS    - count range 0..MODULUS-1 (2..16)
//   DEB_CYCLES - consecutive stable synchronized samples needed to accept a
//                button level change (>= 2)
//
// Ports:
//   clk      - system clock
//   reset    - asynchronous, active-high reset
//   run_btn  - raw run/pause button, active-high, asynchronous to clk
//   step_btn - raw single-step button, active-high, asynchronous to clk
//   dir      - 1 = count up, 0 = count down (sampled in the step cycle)
//   load     - synchronous load strobe (clk domain)
//   load_val - value to load; clamped to MODULUS-1
//   count    - current count, to segment decoder
//   running  - 1 while in RUN
//   tick     - one-cycle pulse in the cycle a stepped count appears
//   wrap     - one-cycle pulse with tick on a wrap (or reversal) step
module hex_count_sequencer #(
  parameter int PRESCALE   = 25000000,
  parameter int MODULUS    = 16,
  parameter int DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [3:0]    CNT_MAX    = 4'(MODULUS - 1);

  // ---------------------------------------------------------------------------
  // Button conditioning: index 0 = run, index 1 = step
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {step_btn, run_btn};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic [1:0]    prime_reg;
      logic [DW-1:0] deb_cnt_reg;
      logic          level_reg;
      logic          level_prev_reg;
      logic          armed_reg;

      // prime_reg fills with ones two cycles after reset, marking the point
      // where sync2_reg holds a real sample rather than its reset value.
      // armed_reg is set only once the button has been seen released with
      // real samples, so a button held through reset never yields a press.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync1_reg      <= 1'b0;
          sync2_reg      <= 1'b0;
          prime_reg      <= 2'b00;
          deb_cnt_reg    <= '0;
          level_reg      <= 1'b0;
          level_prev_reg <= 1'b0;
          armed_reg      <= 1'b0;
        end else begin
          sync1_reg      <= btn_raw[gi];
          sync2_reg      <= sync1_reg;
          prime_reg      <= {prime_reg[0], 1'b1};
          level_prev_reg <= level_reg;

          // Any sample that agrees with the accepted level restarts the run.
          if (sync2_reg == level_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            level_reg   <= sync2_reg;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end

          if (prime_reg[1] && !sync2_reg && !level_reg) begin
            armed_reg <= 1'b1;
          end
        end
      end

      assign press[gi] = armed_reg & level_reg & ~level_prev_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sequencer core
  // ---------------------------------------------------------------------------
  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t        state_reg;
  logic          running_reg;
  logic [PW-1:0] presc_reg;
  logic [3:0]    count_reg;
  logic          tick_reg;
  logic          wrap_reg;

  logic          presc_done;
  logic          step_req;
  logic          up;
  logic [3:0]    count_next;
  logic          wrap_next;

`ifdef HEX_SEQ_BOUNCE_EN
  logic          dir_reg;
  logic          dir_next;
  assign up = dir_reg;
`else
  assign up = dir;
`endif

  assign presc_done = (state_reg == RUN) && (presc_reg == PRESC_LAST);
  // Step presses only act while paused; in RUN the prescaler drives steps.
  assign step_req   = presc_done || ((state_reg == PAUSE) && press[1]);

  // Value the count takes if a step is applied this cycle.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
`ifdef HEX_SEQ_BOUNCE_EN
    dir_next   = dir_reg;
`endif
    if (up) begin
      if (count_reg == CNT_MAX) begin
        wrap_next  = 1'b1;
`ifdef HEX_SEQ_BOUNCE_EN
        count_next = CNT_MAX - 4'd1;
        dir_next   = 1'b0;
`else
        count_next = 4'd0;
`endif
      end else begin
        count_next = count_reg + 4'd1;
      end
    end else begin
      if (count_reg == 4'd0) begin
        wrap_next  = 1'b1;
`ifdef HEX_SEQ_BOUNCE_EN
        count_next = 4'd1;
        dir_next   = 1'b1;
`else
        count_next = CNT_MAX;
`endif
      end else begin
        count_next = count_reg - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= PAUSE;
      running_reg <= 1'b0;
      presc_reg   <= '0;
      count_reg   <= 4'd0;
      tick_reg    <= 1'b0;
      wrap_reg    <= 1'b0;
`ifdef HEX_SEQ_BOUNCE_EN
      dir_reg     <= 1'b1;
`endif
    end else begin
      tick_reg <= 1'b0;
      wrap_reg <= 1'b0;

      // Load wins over any coincident step and restarts the step interval.
      if (load) begin
        count_reg <= (load_val > CNT_MAX) ? CNT_MAX : load_val;
`ifdef HEX_SEQ_BOUNCE_EN
        dir_reg   <= dir;
`endif
      end else if (step_req) begin
        count_reg <= count_next;
        tick_reg  <= 1'b1;
        wrap_reg  <= wrap_next;
`ifdef HEX_SEQ_BOUNCE_EN
        dir_reg   <= dir_next;
`endif
      end

      // Prescaler advances only while staying in RUN; it is zero otherwise,
      // including the cycle RUN is left.
      if (!load && (state_reg == RUN) && !presc_done && !press[0]) begin
        presc_reg <= presc_reg + 1'b1;
      end else begin
        presc_reg <= '0;
      end

      // A coincident prescaler step has already been applied above.
      if (press[0]) begin
        state_reg   <= (state_reg == RUN) ? PAUSE : RUN;
        running_reg <= (state_reg == PAUSE);
      end
    end
  end

  assign count   = count_reg;
  assign running = running_reg;
  assign tick    = tick_reg;
  assign wrap    = wrap_reg;

endmodule

// File: tb/tb_hex_count_sequencer.sv
// Directed testbench for hex_count_sequencer with PRESCALE=4, MODULUS=10,
// DEB_CYCLES=3. Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, so each cyc() step observes the result of
// exactly one clock edge.
module tb_hex_count_sequencer;

  localparam int PRESCALE   = 4;
  localparam int MODULUS    = 10;
  localparam int DEB_CYCLES = 3;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       run_btn  = 1'b0;
  logic       step_btn = 1'b0;
  logic       dir      = 1'b1;
  logic       load     = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] count;
  logic       running;
  logic       tick;
  logic       wrap;

  int n_cmp = 0;
  int n_bad = 0;

  hex_count_sequencer #(
    .PRESCALE  (PRESCALE),
    .MODULUS   (MODULUS),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run_btn (run_btn),
    .step_btn(step_btn),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .running (running),
    .tick    (tick),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    run_btn  = 1'b0;
    step_btn = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    cyc(2);
    reset = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %0b expected 0", running); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %0b expected 0", tick); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %0b expected 0", wrap); end
    cyc(8);
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL idle_count: got %0d expected 0", count); end
    $display("reset: count=%0d running=%0b", count, running);
  endtask

  task automatic test_load_clamp();
    do_reset();
    load = 1'b1; load_val = 4'd5;
    cyc(1);
    load = 1'b0;
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL load_5: got %0d expected 5", count); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL load_5_tick: got %0b expected 0", tick); end
    load = 1'b1; load_val = 4'd15;
    cyc(1);
    load = 1'b0;
    n_cmp++; if (count !== 4'd9) begin n_bad++; $display("FAIL load_clamp: got %0d expected 9", count); end
    $display("load: load_val=15 count=%0d", count);
  endtask

  task automatic test_run_count();
    do_reset();
    dir = 1'b1;
    run_btn = 1'b1;
    cyc(5);
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL run_early: got %0b expected 0", running); end
    cyc(1);
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL run_latency: got %0b expected 1", running); end
    for (int k = 1; k <= 10; k++) begin
      cyc(3);
      n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL run_gap_tick %0d: got %0b expected 0", k, tick); end
      cyc(1);
      n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL run_tick %0d: got %0b expected 1", k, tick); end
      n_cmp++; if (count !== 4'(k % 10)) begin n_bad++; $display("FAIL run_count %0d: got %0d expected %0d", k, count, k % 10); end
      n_cmp++; if (wrap !== (k == 10)) begin n_bad++; $display("FAIL run_wrap %0d: got %0b expected %0b", k, wrap, (k == 10)); end
      $display("run step %0d: count=%0d wrap=%0b", k, count, wrap);
      if (k == 1) run_btn = 1'b0;
    end
    // Second run press returns to PAUSE; one more prescaler step lands first.
    run_btn = 1'b1;
    cyc(5);
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL pause_early: got %0b expected 1", running); end
    cyc(1);
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL pause_latency: got %0b expected 0", running); end
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL pause_count: got %0d expected 1", count); end
    run_btn = 1'b0;
    cyc(10);
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL pause_hold: got %0d expected 1", count); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL pause_release: got %0b expected 0", running); end
  endtask

  task automatic test_step_down();
    do_reset();
    dir = 1'b0;
    step_btn = 1'b1;
    cyc(5);
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL stepdn_early: got %0d expected 0", count); end
    cyc(1);
    n_cmp++; if (count !== 4'd9) begin n_bad++; $display("FAIL stepdn_count: got %0d expected 9", count); end
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL stepdn_tick: got %0b expected 1", tick); end
    n_cmp++; if (wrap !== 1'b1) begin n_bad++; $display("FAIL stepdn_wrap: got %0b expected 1", wrap); end
    cyc(1);
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL stepdn_tick_len: got %0b expected 0", tick); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL stepdn_wrap_len: got %0b expected 0", wrap); end
    step_btn = 1'b0;
    cyc(10);
    n_cmp++; if (count !== 4'd9) begin n_bad++; $display("FAIL stepdn_release: got %0d expected 9", count); end
    step_btn = 1'b1;
    cyc(6);
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL stepdn_second: got %0d expected 8", count); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL stepdn_second_wrap: got %0b expected 0", wrap); end
    step_btn = 1'b0;
    cyc(8);
    $display("step down: count=%0d", count);
  endtask

  task automatic test_bounce_step();
    int pat[5] = '{1, 0, 1, 0, 1};
    int ticks = 0;
    do_reset();
    dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_btn = (pat[i] != 0);
      cyc(1);
      ticks += int'(tick);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      ticks += int'(tick);
    end
    n_cmp++; if (ticks != 0) begin n_bad++; $display("FAIL bounce_early_ticks: got %0d expected 0", ticks); end
    cyc(1);
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL bounce_tick: got %0b expected 1", tick); end
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL bounce_count: got %0d expected 1", count); end
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      ticks += int'(tick);
    end
    n_cmp++; if (ticks != 0) begin n_bad++; $display("FAIL bounce_extra_ticks: got %0d expected 0", ticks); end
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL bounce_final: got %0d expected 1", count); end
    step_btn = 1'b0;
    cyc(8);
    $display("bounced step: count=%0d", count);
  endtask

  task automatic test_load_priority();
    do_reset();
    dir = 1'b1;
    run_btn = 1'b1;
    cyc(6);
    n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL ldp_running: got %0b expected 1", running); end
    run_btn = 1'b0;
    cyc(3);
    load = 1'b1; load_val = 4'd12;
    cyc(1);
    load = 1'b0;
    n_cmp++; if (count !== 4'd9) begin n_bad++; $display("FAIL ldp_count: got %0d expected 9", count); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL ldp_tick: got %0b expected 0", tick); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL ldp_wrap: got %0b expected 0", wrap); end
    cyc(3);
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL ldp_gap_tick: got %0b expected 0", tick); end
    n_cmp++; if (count !== 4'd9) begin n_bad++; $display("FAIL ldp_gap_count: got %0d expected 9", count); end
    cyc(1);
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL ldp_next_tick: got %0b expected 1", tick); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL ldp_next_count: got %0d expected 0", count); end
    n_cmp++; if (wrap !== 1'b1) begin n_bad++; $display("FAIL ldp_next_wrap: got %0b expected 1", wrap); end
    $display("load priority: count=%0d wrap=%0b", count, wrap);
  endtask

  task automatic test_reset_midcount();
    int ticks = 0;
    do_reset();
    dir = 1'b1;
    run_btn = 1'b1;
    cyc(6);
    run_btn = 1'b0;
    cyc(1);
    step_btn = 1'b1;   // a step press while running must be ignored
    cyc(19);
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL mid_count: got %0d expected 5", count); end
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL mid_tick: got %0b expected 1", tick); end
    cyc(2);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL mid_rst_running: got %0b expected 0", running); end
    n_cmp++; if ((tick | wrap) !== 1'b0) begin n_bad++; $display("FAIL mid_rst_pulses: got %0b expected 0", tick | wrap); end
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      ticks += int'(tick);
    end
    n_cmp++; if (ticks != 0) begin n_bad++; $display("FAIL held_ticks: got %0d expected 0", ticks); end
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL held_count: got %0d expected 0", count); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL held_running: got %0b expected 0", running); end
    step_btn = 1'b0;
    cyc(8);
    step_btn = 1'b1;
    cyc(5);
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL repress_early: got %0d expected 0", count); end
    cyc(1);
    n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL repress_tick: got %0b expected 1", tick); end
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL repress_count: got %0d expected 1", count); end
    step_btn = 1'b0;
    cyc(8);
    $display("reset mid-count: count=%0d running=%0b", count, running);
  endtask

`ifdef HEX_SEQ_BOUNCE_EN
  task automatic test_bounce_mode();
    int seq[19] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    do_reset();
    dir = 1'b0;   // ignored in this build
    run_btn = 1'b1;
    cyc(6);
    run_btn = 1'b0;
    for (int i = 0; i < 19; i++) begin
      cyc(4);
      n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL bmode_tick %0d: got %0b expected 1", i, tick); end
      n_cmp++; if (count !== 4'(seq[i])) begin n_bad++; $display("FAIL bmode_count %0d: got %0d expected %0d", i, count, seq[i]); end
      n_cmp++; if (wrap !== (i == 9 || i == 18)) begin n_bad++; $display("FAIL bmode_wrap %0d: got %0b expected %0b", i, wrap, (i == 9 || i == 18)); end
      $display("bounce step %0d: count=%0d wrap=%0b", i, count, wrap);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_clamp();
`ifdef HEX_SEQ_BOUNCE_EN
    test_bounce_mode();
`else
    test_run_count();
    test_step_down();
    test_bounce_step();
    test_load_priority();
    test_reset_midcount();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
